// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter_ctrl sequencing controller.
// Optional build macro: PRESCALER_EN (see counter_ctrl.sv).
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10,
    PAUSE = 2'b11
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_ctrl_count_core.sv
// count_core: WIDTH-bit up-counter with synchronous clear, tick enable and
// terminal compare against the latched limit.
module count_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             term_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign term_o  = (count_q == limit_i);
  assign count_o = count_q;

  // Next count: clear wins, a terminal tick wraps to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      if (term_o) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: config handshake plus IDLE/ARMED/RUN/PAUSE sequencer around
// count_core. Optional build macro: PRESCALER_EN adds the presc_div divider.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef PRESCALER_EN
  ,
  parameter int PRESC_WIDTH = 4
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [WIDTH-1:0]       cfg_limit,
  input  logic                   cfg_periodic,
`ifdef PRESCALER_EN
  input  logic [PRESC_WIDTH-1:0] presc_div,
`endif
  input  logic                   start,
  input  logic                   stop,
  output logic [WIDTH-1:0]       count,
  output logic                   busy,
  output logic                   done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;
  logic             ready_q, busy_q;
  logic             xfer_s, tick_s, term_s, term_tick_s, adv_s, clear_s;

  assign xfer_s      = cfg_valid & ready_q;
  assign term_tick_s = tick_s & term_s;
  // A stop freezes the count unless this tick is terminal, which always completes.
  assign adv_s       = tick_s & (~stop | term_s);

`ifdef PRESCALER_EN
  logic [PRESC_WIDTH-1:0] div_q, div_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;

  assign tick_s = (state_q == RUN) && (presc_q == div_q);

  // Prescaler restarts on ARMED->RUN and advances with the count.
  always_comb begin
    div_d   = div_q;
    presc_d = presc_q;
    if (xfer_s) begin
      div_d = presc_div;
    end else begin
      div_d = div_q;
    end
    if ((state_q == ARMED) && (state_d == RUN)) begin
      presc_d = '0;
    end else if ((state_q == RUN) && (~stop | term_tick_s)) begin
      presc_d = tick_s ? '0 : presc_q + PRESC_WIDTH'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Prescaler registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      presc_q <= '0;
    end else begin
      div_q   <= div_d;
      presc_q <= presc_d;
    end
  end
`else
  assign tick_s = (state_q == RUN);
`endif

  // Sequencer: a config transfer beats any command; stop beats start.
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    clear_s    = 1'b0;
    if (xfer_s) begin
      limit_d    = cfg_limit;
      periodic_d = cfg_periodic;
      clear_s    = 1'b1;
      state_d    = ARMED;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        ARMED: begin
          if (start && !stop) begin
            state_d = RUN;
          end else begin
            state_d = ARMED;
          end
        end
        RUN: begin
          if (term_tick_s) begin
            done_d = 1'b1;
            if (periodic_q == MODE_PERIODIC) begin
              state_d = stop ? PAUSE : RUN;
            end else begin
              state_d = ARMED;
            end
          end else if (stop) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (stop) begin
            state_d = ARMED;
            clear_s = 1'b1;
          end else if (start) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers; ready/busy are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      periodic_q <= MODE_ONESHOT;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
      ready_q    <= (state_d == IDLE) || (state_d == ARMED);
      busy_q     <= (state_d == RUN);
    end
  end

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_s),
    .tick_i  (adv_s),
    .limit_i (limit_q),
    .count_o (count),
    .term_o  (term_s)
  );

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
